// File: rtl/rvsteel_board_ctrl_pkg.sv
// rvsteel_board_ctrl_pkg: sequencer state encoding and reset-cause codes
package rvsteel_board_ctrl_pkg;
    typedef enum logic [1:0] {
        HOLD         = 2'd0,
        RUN          = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;
    localparam logic [1:0] CAUSE_POR    = 2'b00;
    localparam logic [1:0] CAUSE_BUTTON = 2'b01;
endpackage

// File: rtl/rvsteel_debouncer.sv
// rvsteel_debouncer: two-flop synchronizer plus stable-count debouncer for one button
module rvsteel_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic stable
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync;
    logic [CW-1:0] count;
    // the cycle that would bring the count to DEBOUNCE_CYCLES commits the new level
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync   <= '0;
            count  <= '0;
            stable <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == stable) begin
                count <= '0;
            end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync[1];
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end
endmodule

// File: rtl/rvsteel_board_ctrl.sv
// rvsteel_board_ctrl: board reset/halt sequencer; RVSTEEL_HALT_LATCH_EN selects toggle-mode halt
module rvsteel_board_ctrl
    import rvsteel_board_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int RESET_HOLD_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       reset_button,
    input  logic       halt_button,
    output logic       soc_reset,
    output logic       soc_halt,
    output logic [1:0] reset_cause
);
    localparam int HW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);
    state_t        state, next;
    logic [HW-1:0] hold;
    logic          reset_db, halt_db, enter_wait;

    rvsteel_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset_db (
        .clock(clock), .reset_n(reset_n), .raw(reset_button), .stable(reset_db)
    );
    rvsteel_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_halt_db (
        .clock(clock), .reset_n(reset_n), .raw(halt_button), .stable(halt_db)
    );

    // a held reset button always wins, including over an expiring hold count
    always_comb begin
        next = reset_db ? WAIT_RELEASE :
               (state == WAIT_RELEASE) ? HOLD :
               (state == RUN) ? RUN :
               (state == HOLD && hold == HOLD_LAST) ? RUN : HOLD;
        enter_wait = (next == WAIT_RELEASE) && (state != WAIT_RELEASE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= HOLD;
            hold        <= '0;
            soc_reset   <= 1'b1;
            reset_cause <= CAUSE_POR;
        end else begin
            state     <= next;
            hold      <= (state == HOLD && next == HOLD) ? hold + 1'b1 : '0;
            soc_reset <= (next != RUN);
            if (state == WAIT_RELEASE && next == HOLD)
                reset_cause <= CAUSE_BUTTON;
        end
    end

`ifdef RVSTEEL_HALT_LATCH_EN
    logic halt_prev;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            halt_prev <= 1'b0;
            soc_halt  <= 1'b0;
        end else begin
            halt_prev <= halt_db;
            soc_halt  <= enter_wait ? 1'b0 : soc_halt ^ (halt_db & ~halt_prev);
        end
    end
`else
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            soc_halt <= 1'b0;
        else
            soc_halt <= halt_db;
    end
`endif
endmodule

// File: doc/rvsteel_board_ctrl.md
# rvsteel_board_ctrl

Board-level reset and halt sequencer that sits between raw push-button inputs and the `rvsteel_soc` `reset`/`halt` pins.

- Each button goes through a two-flop synchronizer and a counter-based debouncer.
- The block stretches every SoC reset to a guaranteed minimum width.
- It records the cause of the last reset.
- Replaces ad-hoc single-flop button sampling in board tops.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 500000. Consecutive stable cycles required before a button change is accepted. Legal range is 1 or more.
- `RESET_HOLD_CYCLES`, default 16. Minimum number of cycles `soc_reset` stays high after the reset button is released or after power-on. Legal range is 1 or more.

Ports:
- `clock`  input  1: system clock; all state on rising edge.
- `reset_n`  input  1: asynchronous, active-low board reset. Asynchronous assertion; synchronous deassertion by the board.
- `reset_button`  input  1: raw reset button, active-high, asynchronous to `clock`.
- `halt_button`  input  1: raw halt button, active-high, asynchronous to `clock`.
- `soc_reset`  output  1: registered, active-high reset to the SoC.
- `soc_halt`  output  1: registered, active-high halt to the SoC.
- `reset_cause`  output  2: cause of the last reset. `2'b00` = power-on, `2'b01` = button. `2'b1x` is reserved and never driven.

## Operation

- While `reset_n` is low:
  - state = HOLD, hold counter = 0.
  - `soc_reset`=1, `soc_halt`=0, `reset_cause`=00.
  - Synchronizers, debounced outputs and debounce counters are all 0.
- Synchronizer: two flops per button.
- Debouncer:
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - When the synchronized input differs from the debounced output, the counter increments.
  - When they are equal, the counter clears to 0.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced output takes the input value and the counter clears.
- FSM, three states:
  - HOLD:
    - `soc_reset`=1; hold counter increments each cycle.
    - If debounced reset = 1, go to WAIT_RELEASE. This check has priority.
    - Else, when hold counter = `RESET_HOLD_CYCLES-1`, go to RUN.
  - RUN:
    - `soc_reset`=0.
    - On debounced reset = 1, go to WAIT_RELEASE.
  - WAIT_RELEASE:
    - `soc_reset`=1.
    - On debounced reset = 0, go to HOLD, clear the hold counter, and set `reset_cause`=01.
- `soc_reset` is registered and equals 1 in the next state unless that next state is RUN. Deassertion is therefore glitch-free and synchronous to `clock`.
- Halt in level mode: `soc_halt` follows debounced halt with a one-register delay.
- Reset and halt are independent: halt may be asserted during HOLD or WAIT_RELEASE.
- Hold counter width is `$clog2(RESET_HOLD_CYCLES)`, minimum 1. It never wraps, because it clears on entry to HOLD.

## Timing

- Raw button edge to debounced edge: 2 + `DEBOUNCE_CYCLES` cycles, with the input held stable throughout.
- Reset press to `soc_reset` high:
  - From RUN: debounced edge + 1 cycle.
  - From HOLD: `soc_reset` is already high; the FSM moves to WAIT_RELEASE.
- Reset release to `soc_reset` low: debounced falling edge + 1 cycle into HOLD + `RESET_HOLD_CYCLES` cycles.
- After `reset_n` deassertion: `soc_reset` falls exactly `RESET_HOLD_CYCLES` cycles later, provided no button is pressed.
- Glitch rejection: a pulse shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no output change.
- Simultaneous reset and halt debounced edges are both applied in the same cycle.
- Asserting `reset_n` mid-operation aborts everything immediately and restores the reset values, including `reset_cause`=00.

## Configuration

- `RVSTEEL_HALT_LATCH_EN` defined:
  - `soc_halt` toggles on each debounced rising edge of `halt_button`. Release has no effect.
  - The latch clears to 0 on entry to WAIT_RELEASE, so a button reset always resumes execution.
  - Adds one edge-detect flop.
- Not defined: level mode as described in Operation. The SoC halts only while the button is held.

## Structure

- Package `rvsteel_board_ctrl_pkg`:
  - State encoding localparams: HOLD=2'd0, RUN=2'd1, WAIT_RELEASE=2'd2.
  - Reset-cause constants: CAUSE_POR=2'b00, CAUSE_BUTTON=2'b01.
- Sub-module `rvsteel_debouncer`:
  - Parameter `DEBOUNCE_CYCLES`; ports `clock`, `reset_n`, `raw`, `stable`.
  - Contains the synchronizer and counter.
  - Instantiated twice.
- FSM, hold counter and halt logic live in the top module.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4 and `RESET_HOLD_CYCLES`=8.

- Power-on: release `reset_n` with buttons at 0 → `soc_reset`=1 for exactly 8 cycles, then 0; `reset_cause`=00; `soc_halt`=0.
- Button reset: in RUN, hold `reset_button` for 20 cycles then release → `soc_reset` rises 7 cycles after the press and falls 2+4+1+8 cycles after release; `reset_cause`=01.
- Glitch: 3-cycle pulse on `reset_button` in RUN → `soc_reset` stays 0; debounce counter returns to 0.
- Halt, level mode: hold `halt_button` for 30 cycles → `soc_halt` high from the press + 7 cycles to the release + 7 cycles.
- Halt, `RVSTEEL_HALT_LATCH_EN`: two separate 10-cycle presses → `soc_halt` goes 1, then 0. After one press followed by a button reset, `soc_halt`=0 on entry to WAIT_RELEASE.
- Async abort: assert `reset_n` during WAIT_RELEASE with `reset_cause`=01 → all outputs return to reset values in the same cycle; power-on sequence repeats after release.
